// File: rtl/mult_div_seq.sv
// mult_div_seq: multi-cycle unsigned MULTU/DIVU sequencer
// Borrows the shared 32-bit ALU one add/subtract step per granted cycle.
module mult_div_seq #(
   parameter logic [2:0] ALU_ADD = 3'b010,
   parameter logic [2:0] ALU_SUB = 3'b110
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic        op,
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic        alu_gnt,
   input  logic [31:0] alu_result,
   input  logic        alu_cout,
   output logic        alu_req,
   output logic [31:0] alu_a,
   output logic [31:0] alu_b,
   output logic [2:0]  alu_op,
   output logic        busy,
   output logic        done,
   output logic        div_by_zero,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_e;

   state_e      state_q;
   logic [5:0]  cnt_q;
   logic [31:0] m_q;
   logic        op_q;
   logic [31:0] hi_q;
   logic [31:0] lo_q;
   logic        busy_q;
   logic        done_q;
   logic        dbz_q;

   logic [31:0] div_shift;
   logic        div_ge;

   // Partial remainder shifted left by one, and the restoring-divide compare
   assign div_shift = {hi_q[30:0], lo_q[31]};
   assign div_ge    = hi_q[31] | alu_cout;

   // ALU operands are driven only while iterating; idle value is a quiet ADD of zeros
   always_comb begin
      alu_a  = '0;
      alu_b  = '0;
      alu_op = ALU_ADD;
      if (state_q == S_RUN) begin
         alu_b = m_q;
         if (op_q) begin
            alu_op = ALU_SUB;
            alu_a  = div_shift;
         end else begin
            alu_a  = hi_q;
         end
      end
   end

   assign alu_req     = (state_q == S_RUN);
   assign busy        = busy_q;
   assign done        = done_q;
   assign div_by_zero = dbz_q;
   assign hi          = hi_q;
   assign lo          = lo_q;

   // Sequencer: launch, one shift-add or shift-subtract per grant, then a done pulse
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         m_q     <= '0;
         op_q    <= 1'b0;
         hi_q    <= '0;
         lo_q    <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         dbz_q   <= 1'b0;
      end else begin
         unique case (state_q)
            S_IDLE: begin
               done_q <= 1'b0;
               if (start) begin
                  op_q   <= op;
                  m_q    <= b;
                  cnt_q  <= '0;
                  busy_q <= 1'b1;
                  if (op && (b == 32'd0)) begin
                     hi_q    <= a;
                     lo_q    <= 32'hFFFF_FFFF;
                     dbz_q   <= 1'b1;
                     done_q  <= 1'b1;
                     state_q <= S_DONE;
                  end else begin
                     hi_q    <= '0;
                     lo_q    <= a;
                     dbz_q   <= 1'b0;
                     state_q <= S_RUN;
                  end
               end
            end
            S_RUN: begin
               if (alu_gnt) begin
                  cnt_q <= cnt_q + 6'd1;
                  if (op_q) begin
                     hi_q <= div_ge ? alu_result : div_shift;
                     lo_q <= {lo_q[30:0], div_ge};
                  end else if (lo_q[0]) begin
                     hi_q <= {alu_cout, alu_result[31:1]};
                     lo_q <= {alu_result[0], lo_q[31:1]};
                  end else begin
                     hi_q <= {1'b0, hi_q[31:1]};
                     lo_q <= {hi_q[0], lo_q[31:1]};
                  end
                  if (cnt_q == 6'd31) begin
                     done_q  <= 1'b1;
                     state_q <= S_DONE;
                  end
               end
            end
            S_DONE: begin
               done_q  <= 1'b0;
               busy_q  <= 1'b0;
               state_q <= S_IDLE;
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mult_div_seq.sv
// tb_mult_div_seq: table vectors, corner sequences and random ops
// against an arithmetic reference model and a behavioural shared ALU.
module tb_mult_div_seq;

   localparam logic [2:0] ADD = 3'b010;
   localparam logic [2:0] SUB = 3'b110;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic        op;
   logic [31:0] a;
   logic [31:0] b;
   logic        gnt;
   logic [31:0] alu_result;
   logic        alu_cout;
   logic        alu_req;
   logic [31:0] alu_a;
   logic [31:0] alu_b;
   logic [2:0]  alu_op;
   logic        busy;
   logic        done;
   logic        dbz;
   logic [31:0] hi;
   logic [31:0] lo;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   mult_div_seq #(.ALU_ADD(ADD), .ALU_SUB(SUB)) dut (
      .clk(clk), .reset(reset), .start(start), .op(op),
      .a(a), .b(b), .alu_gnt(gnt),
      .alu_result(alu_result), .alu_cout(alu_cout),
      .alu_req(alu_req), .alu_a(alu_a), .alu_b(alu_b),
      .alu_op(alu_op), .busy(busy), .done(done),
      .div_by_zero(dbz), .hi(hi), .lo(lo)
   );

   // Shared ALU: add, or subtract as A + ~B + 1
   logic [32:0] alu_sum;
   always_comb begin
      alu_sum = {1'b0, alu_a}
              + {1'b0, (alu_op[2] ? ~alu_b : alu_b)}
              + {32'd0, (alu_op[2] & ~alu_op[0])};
      alu_result = alu_sum[31:0];
      alu_cout   = alu_sum[32];
   end

   // Reference: {div_by_zero, hi, lo}
   function automatic logic [64:0] ref_model(bit o, logic [31:0] x, logic [31:0] y);
      logic [63:0] p;
      if (!o) begin
         p = {32'd0, x} * {32'd0, y};
         return {1'b0, p};
      end
      if (y == 0) return {1'b1, x, 32'hFFFF_FFFF};
      return {1'b0, x % y, x / y};
   endfunction

   task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic run_op(input bit o, input logic [31:0] x, input logic [31:0] y,
                         input logic [63:0] mask, input bit inj,
                         output logic [31:0] rh, output logic [31:0] rl,
                         output bit rz, output int lat, output int nst);
      bit seen;
      bit pstall;
      logic [31:0] pa, pb, ph, pl;
      logic [2:0] pop;
      start = 1'b1; op = o; a = x; b = y; gnt = 1'b1;
      @(posedge clk); #1;
      start = 1'b0; a = $urandom; b = $urandom;
      lat = 0; nst = 0; seen = 0; pstall = 0;
      pa = '0; pb = '0; ph = '0; pl = '0; pop = '0;
      for (int k = 0; k < 200 && !seen; k++) begin
         gnt = (k < 64) ? !mask[k] : 1'b1;
         if (inj && k == 5) begin
            start = 1'b1; op = !o;
         end else begin
            start = 1'b0;
         end
         if (alu_req && !gnt) nst++;
         @(negedge clk);
         if (pstall) begin
            chk("stall_alu_a", {32'd0, alu_a}, {32'd0, pa});
            chk("stall_alu_b", {32'd0, alu_b}, {32'd0, pb});
            chk("stall_alu_op", {61'd0, alu_op}, {61'd0, pop});
            chk("stall_hilo", {hi, lo}, {ph, pl});
         end
         pstall = alu_req && !gnt;
         pa = alu_a; pb = alu_b; pop = alu_op; ph = hi; pl = lo;
         if (done) begin
            seen = 1;
         end else begin
            chk("busy_run", {63'd0, busy}, 64'd1);
            @(posedge clk); #1;
            lat++;
         end
      end
      if (!seen) begin
         checks++; errors++;
         $display("FAIL timeout: got no done expected done within 200 cycles");
      end
      rh = hi; rl = lo; rz = dbz;
      // start during the DONE cycle must be ignored
      start = 1'b1; op = 1'b0; a = 32'd3; b = 32'd3;
      @(posedge clk); #1;
      start = 1'b0; gnt = 1'b1;
      @(negedge clk);
      chk("done_one_cycle", {63'd0, done}, 64'd0);
      chk("busy_after", {63'd0, busy}, 64'd0);
      chk("hold_result", {hi, lo}, {rh, rl});
   endtask

   typedef struct {
      bit          o;
      logic [31:0] x;
      logic [31:0] y;
      logic [31:0] eh;
      logic [31:0] el;
      bit          ez;
      logic [63:0] mask;
      bit          inj;
      int          elat;
   } vec_t;

   vec_t vt[8];

   initial begin
      logic [31:0] rh, rl;
      bit rz;
      int lat, nst;
      logic [64:0] e;
      bit o;
      logic [31:0] x, y;
      logic [63:0] mk;

      vt[0] = '{0, 32'd7, 32'd6, 32'd0, 32'd42, 0, 64'd0, 0, 32};
      vt[1] = '{0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h1, 0, 64'd0, 0, 32};
      vt[2] = '{1, 32'd100, 32'd7, 32'd2, 32'd14, 0, 64'd0, 0, 32};
      vt[3] = '{1, 32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF, 32'h1, 0, 64'd0, 0, 32};
      vt[4] = '{1, 32'd5, 32'd0, 32'd5, 32'hFFFFFFFF, 1, 64'd0, 0, 0};
      vt[5] = '{0, 32'd3, 32'd5, 32'd0, 32'd15, 0, 64'h24489192, 1, 42};
      vt[6] = '{1, 32'd0, 32'd1, 32'd0, 32'd0, 0, 64'd0, 0, 32};
      vt[7] = '{0, 32'h10000, 32'h10000, 32'd1, 32'd0, 0, 64'd0, 0, 32};

      reset = 1'b1; start = 1'b0; op = 1'b0; a = '0; b = '0; gnt = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_hilo", {hi, lo}, 64'd0);
      chk("rst_busy", {63'd0, busy}, 64'd0);
      chk("rst_done", {63'd0, done}, 64'd0);
      chk("rst_req", {63'd0, alu_req}, 64'd0);
      chk("rst_dbz", {63'd0, dbz}, 64'd0);
      chk("rst_alu", {29'd0, alu_op, alu_a}, {29'd0, ADD, 32'd0});
      @(posedge clk); #1;
      reset = 1'b0;

      for (int i = 0; i < 8; i++) begin
         run_op(vt[i].o, vt[i].x, vt[i].y, vt[i].mask, vt[i].inj, rh, rl, rz, lat, nst);
         chk($sformatf("vec%0d_hilo", i), {rh, rl}, {vt[i].eh, vt[i].el});
         chk($sformatf("vec%0d_dbz", i), {63'd0, rz}, {63'd0, vt[i].ez});
         chk($sformatf("vec%0d_lat", i), lat, vt[i].elat);
      end

      // Reset during RUN iteration 16
      @(posedge clk); #1;
      start = 1'b1; op = 1'b0; a = 32'h1234; b = 32'h5678; gnt = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (16) @(posedge clk);
      #1 reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      @(negedge clk);
      chk("midrst_hilo", {hi, lo}, 64'd0);
      chk("midrst_busy", {63'd0, busy}, 64'd0);
      chk("midrst_req", {63'd0, alu_req}, 64'd0);
      begin
         bit any_done;
         any_done = 0;
         for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (done || busy) any_done = 1;
         end
         chk("midrst_quiet", {63'd0, any_done}, 64'd0);
      end
      @(posedge clk); #1;
      run_op(0, 32'h1234, 32'h5678, 64'd0, 0, rh, rl, rz, lat, nst);
      chk("after_rst_hilo", {rh, rl}, 64'h1234 * 64'h5678);

      // Random operations with random stall patterns
      for (int i = 0; i < 30; i++) begin
         o = 1'($urandom_range(0, 1));
         x = $urandom;
         case ($urandom_range(0, 5))
            0: y = 32'd0;
            1: y = 32'($urandom_range(1, 255));
            default: y = $urandom;
         endcase
         mk = ($urandom_range(0, 1) == 1) ? ({$urandom, $urandom} & {$urandom, $urandom}) : 64'd0;
         e = ref_model(o, x, y);
         @(posedge clk); #1;
         run_op(o, x, y, mk, 1'($urandom_range(0, 1)), rh, rl, rz, lat, nst);
         chk($sformatf("rnd%0d_hilo", i), {rh, rl}, e[63:0]);
         chk($sformatf("rnd%0d_dbz", i), {63'd0, rz}, {63'd0, e[64]});
         chk($sformatf("rnd%0d_lat", i), lat, e[64] ? 0 : 32 + nst);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
